cell_mux_scanner: RTL

CELL_MUX_SCANNER -- requirements
Module: cell_mux_scanner

---
 rtl/cell_mux_pkg.sv | 23 ++
 rtl/scan_misr8.sv | 23 ++
 rtl/cell_mux_scanner.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/cell_mux_pkg.sv
// Shared types and constants for the cell-mux page scanner and its MISR.
package cell_mux_pkg;

  localparam int PAGE_W = 6;
  localparam int IN_W   = 6;
  localparam int OUT_W  = 8;

  // Feedback taps on sig[7], sig[5], sig[4], sig[3]
  localparam logic [OUT_W-1:0] MISR_TAPS = 8'b1011_1000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } scan_state_t;

  function automatic logic [OUT_W-1:0] misr_step(input logic [OUT_W-1:0] sig,
                                                 input logic [OUT_W-1:0] data);
    return {sig[OUT_W-2:0], ^(sig & MISR_TAPS)} ^ data;
  endfunction

endpackage

// File: rtl/scan_misr8.sv
// 8-bit multiple-input signature register folding one cell-mux sample per enable.
module scan_misr8
  import cell_mux_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             enable,
  input  logic [OUT_W-1:0] data,
  output logic [OUT_W-1:0] sig
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig <= '0;
    end else if (clear) begin
      sig <= '0;
    end else if (enable) begin
      sig <= misr_step(sig, data);
    end
  end

endmodule

// File: rtl/cell_mux_scanner.sv
// Steps a cell mux through a page range, settling dwell+1 cycles per page and strobing one sample each.
// Define SCAN_SIGNATURE_EN to compress the samples into an 8-bit MISR signature; otherwise it reads 0.
//
//   state  | meaning
//   IDLE   | waiting for start; outputs hold their last values
//   SETTLE | page applied, settle counter running down to 0
//   SAMPLE | capture cm_out, then advance page or finish
//   DONE   | single cycle that raises done on the way back to IDLE
module cell_mux_scanner
  import cell_mux_pkg::*;
#(
  parameter int DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [PAGE_W-1:0]  page_lo,
  input  logic [PAGE_W-1:0]  page_hi,
  input  logic [IN_W-1:0]    in_vec,
  input  logic [DWELL_W-1:0] dwell,
  output logic [PAGE_W-1:0]  cm_page,
  output logic [IN_W-1:0]    cm_in,
  input  logic [OUT_W-1:0]   cm_out,
  output logic               busy,
  output logic               done,
  output logic               sample_valid,
  output logic [PAGE_W-1:0]  sample_page,
  output logic [OUT_W-1:0]   sample_data,
  output logic [OUT_W-1:0]   signature
);

  scan_state_t        state_q, state_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [DWELL_W-1:0] dwell_q;
  logic [PAGE_W-1:0]  page_hi_q;
  logic               launch, advance, capture, finish;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    launch  = 1'b0;
    advance = 1'b0;
    capture = 1'b0;
    finish  = 1'b0;
    if (abort) begin
      // Abort suppresses every side effect of the current state, including a pending sample or done.
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            launch  = 1'b1;
            cnt_d   = dwell;
            state_d = SETTLE;
          end
        end
        SETTLE: begin
          if (cnt_q == '0) begin
            state_d = SAMPLE;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        SAMPLE: begin
          capture = 1'b1;
          if (cm_page == page_hi_q) begin
            state_d = DONE;
          end else begin
            advance = 1'b1;
            cnt_d   = dwell_q;
            state_d = SETTLE;
          end
        end
        DONE: begin
          finish  = 1'b1;
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign busy = (state_q != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      page_hi_q    <= '0;
      dwell_q      <= '0;
      cm_page      <= '0;
      cm_in        <= '0;
      sample_valid <= 1'b0;
      sample_page  <= '0;
      sample_data  <= '0;
      done         <= 1'b0;
    end else begin
      sample_valid <= capture;
      done         <= finish;
      if (launch) begin
        page_hi_q <= page_hi;
        dwell_q   <= dwell;
        cm_page   <= page_lo;
        cm_in     <= in_vec;
      end
      // Natural 6-bit wrap gives the page_lo..63, 0..page_hi scan order.
      if (advance) begin
        cm_page <= cm_page + 6'd1;
      end
      if (capture) begin
        sample_page <= cm_page;
        sample_data <= cm_out;
      end
    end
  end

`ifdef SCAN_SIGNATURE_EN
  scan_misr8 u_misr (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (launch),
    .enable (capture),
    .data   (cm_out),
    .sig    (signature)
  );
`else
  assign signature = '0;
`endif

endmodule
